// File: rtl/cbus_pkg.sv
// Shared constants for the C-bus register bank: default data width and the
// destination codes, which double as the B-bus selector codes 0-6.
package cbus_pkg;

   localparam int WIDTH_DEF = 16;

   typedef enum logic [2:0] {
      DST_PC = 3'd0,
      DST_DR = 3'd1,
      DST_R1 = 3'd2,
      DST_R2 = 3'd3,
      DST_R3 = 3'd4,
      DST_R4 = 3'd5,
      DST_R5 = 3'd6,
      DST_AC = 3'd7
   } dst_e;

endpackage

// File: rtl/inc_reg.sv
// Counting register used for PC, R1 and R2.
// Fixed priority: load > clear > increment; the increment wraps all-ones to 0.
module inc_reg
   import cbus_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEF
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             ld,
   input  logic [WIDTH-1:0] ld_val,
   input  logic             clr,
   input  logic             inc,
   output logic [WIDTH-1:0] q
);

   localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

   logic [WIDTH-1:0] val_d;
   logic [WIDTH-1:0] val_q;

   always_comb begin
      val_d = val_q;
      if (ld) begin
         val_d = ld_val;
      end else if (clr) begin
         val_d = '0;
      end else if (inc) begin
         val_d = val_q + ONE;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         val_q <= '0;
      end else begin
         val_q <= val_d;
      end
   end

   assign q = val_q;

endmodule

// File: rtl/cbus_reg_bank.sv
// C-bus write-back register bank: PC/DR/R1-R5/AC plus the AC zero flag.
// Optional build macro CBUS_CLR_EN adds the c_clr port (per-register clear).
module cbus_reg_bank
   import cbus_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEF
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             c_wr,
   input  logic [2:0]       c_flag,
   input  logic [WIDTH-1:0] C_bus,
   input  logic [2:0]       inc_flag,
   input  logic             mem_ld,
   input  logic [WIDTH-1:0] mem_data,
`ifdef CBUS_CLR_EN
   input  logic             c_clr,
`endif
   output logic [WIDTH-1:0] PC,
   output logic [WIDTH-1:0] DR,
   output logic [WIDTH-1:0] R1,
   output logic [WIDTH-1:0] R2,
   output logic [WIDTH-1:0] R3,
   output logic [WIDTH-1:0] R4,
   output logic [WIDTH-1:0] R5,
   output logic [WIDTH-1:0] AC,
   output logic             z_flag
);

   logic             clr_req;
   logic [7:0]       wr_hit;
   logic [7:0]       clr_hit;

   logic [WIDTH-1:0] dr_d, dr_q;
   logic [WIDTH-1:0] r3_d, r3_q;
   logic [WIDTH-1:0] r4_d, r4_q;
   logic [WIDTH-1:0] r5_d, r5_q;
   logic [WIDTH-1:0] ac_d, ac_q;
   logic             z_d, z_q;

   // A write on the same cycle as a clear always wins.
`ifdef CBUS_CLR_EN
   assign clr_req = c_clr & ~c_wr;
`else
   assign clr_req = 1'b0;
`endif

   always_comb begin
      wr_hit          = '0;
      clr_hit         = '0;
      wr_hit[c_flag]  = c_wr;
      clr_hit[c_flag] = clr_req;
   end

   function automatic logic [WIDTH-1:0] ld_or_clr(input logic [WIDTH-1:0] cur,
                                                  input logic             wr,
                                                  input logic             clr,
                                                  input logic [WIDTH-1:0] val);
      logic [WIDTH-1:0] nxt;
      nxt = cur;
      if (wr) begin
         nxt = val;
      end else if (clr) begin
         nxt = '0;
      end
      return nxt;
   endfunction

   inc_reg #(.WIDTH(WIDTH)) u_pc (
      .clk    (clk),
      .rst    (rst),
      .ld     (wr_hit[DST_PC]),
      .ld_val (C_bus),
      .clr    (clr_hit[DST_PC]),
      .inc    (inc_flag[0]),
      .q      (PC)
   );

   inc_reg #(.WIDTH(WIDTH)) u_r1 (
      .clk    (clk),
      .rst    (rst),
      .ld     (wr_hit[DST_R1]),
      .ld_val (C_bus),
      .clr    (clr_hit[DST_R1]),
      .inc    (inc_flag[1]),
      .q      (R1)
   );

   inc_reg #(.WIDTH(WIDTH)) u_r2 (
      .clk    (clk),
      .rst    (rst),
      .ld     (wr_hit[DST_R2]),
      .ld_val (C_bus),
      .clr    (clr_hit[DST_R2]),
      .inc    (inc_flag[2]),
      .q      (R2)
   );

   always_comb begin
      // The memory load path outranks any C-bus activity targeting DR.
      dr_d = mem_ld ? mem_data : ld_or_clr(dr_q, wr_hit[DST_DR], clr_hit[DST_DR], C_bus);
      r3_d = ld_or_clr(r3_q, wr_hit[DST_R3], clr_hit[DST_R3], C_bus);
      r4_d = ld_or_clr(r4_q, wr_hit[DST_R4], clr_hit[DST_R4], C_bus);
      r5_d = ld_or_clr(r5_q, wr_hit[DST_R5], clr_hit[DST_R5], C_bus);
      ac_d = ld_or_clr(ac_q, wr_hit[DST_AC], clr_hit[DST_AC], C_bus);
      z_d  = z_q;
      if (wr_hit[DST_AC] || clr_hit[DST_AC]) begin
         z_d = (ac_d == '0);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         dr_q <= '0;
         r3_q <= '0;
         r4_q <= '0;
         r5_q <= '0;
         ac_q <= '0;
         z_q  <= 1'b1;
      end else begin
         dr_q <= dr_d;
         r3_q <= r3_d;
         r4_q <= r4_d;
         r5_q <= r5_d;
         ac_q <= ac_d;
         z_q  <= z_d;
      end
   end

   assign DR     = dr_q;
   assign R3     = r3_q;
   assign R4     = r4_q;
   assign R5     = r5_q;
   assign AC     = ac_q;
   assign z_flag = z_q;

endmodule

// File: tb/tb_cbus_reg_bank.sv
// Scoreboard bench for cbus_reg_bank: directed cases plus random traffic,
// checked against a register-array reference model.
module tb_cbus_reg_bank;

   typedef struct packed {
      logic [7:0][15:0] r;
      logic             z;
   } exp_t;

`ifdef CBUS_CLR_EN
   localparam bit CLR_BUILT = 1'b1;
`else
   localparam bit CLR_BUILT = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst;
   logic        c_wr;
   logic [2:0]  c_flag;
   logic [15:0] C_bus;
   logic [2:0]  inc_flag;
   logic        mem_ld;
   logic [15:0] mem_data;
   logic        c_clr;
   logic [15:0] PC, DR, R1, R2, R3, R4, R5, AC;
   logic        z_flag;

   logic [15:0] dut_r [8];
   int          mdl [8];
   logic        mz;
   exp_t        exp_q [$];
   int          total = 0;
   int          bad = 0;
   string       nm [8] = '{"PC", "DR", "R1", "R2", "R3", "R4", "R5", "AC"};

   always #5 clk = ~clk;

   cbus_reg_bank #(.WIDTH(16)) dut (
      .clk      (clk),
      .rst      (rst),
      .c_wr     (c_wr),
      .c_flag   (c_flag),
      .C_bus    (C_bus),
      .inc_flag (inc_flag),
      .mem_ld   (mem_ld),
      .mem_data (mem_data),
`ifdef CBUS_CLR_EN
      .c_clr    (c_clr),
`endif
      .PC       (PC),
      .DR       (DR),
      .R1       (R1),
      .R2       (R2),
      .R3       (R3),
      .R4       (R4),
      .R5       (R5),
      .AC       (AC),
      .z_flag   (z_flag)
   );

   always_comb begin
      dut_r[0] = PC;
      dut_r[1] = DR;
      dut_r[2] = R1;
      dut_r[3] = R2;
      dut_r[4] = R3;
      dut_r[5] = R4;
      dut_r[6] = R5;
      dut_r[7] = AC;
   end

   task automatic chk(input string name, input logic [15:0] act, input logic [15:0] expv);
      total++;
      if (act !== expv) begin
         bad++;
         $display("FAIL %s at %0t: got %h expected %h", name, $time, act, expv);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < 8; i++) mdl[i] = 0;
      mz = 1'b1;
   endtask

   // Reference: per register, the highest-priority request decides the next value.
   task automatic model_step(input logic wr, input logic [2:0] fl, input logic [15:0] cb,
                             input logic [2:0] inc, input logic ld, input logic [15:0] md,
                             input logic cl);
      int  nxt [8];
      bit  inc_tgt;
      for (int i = 0; i < 8; i++) begin
         inc_tgt = (i == 0 && inc[0]) || (i == 2 && inc[1]) || (i == 3 && inc[2]);
         if (i == 1 && ld)                nxt[i] = int'(md);
         else if (wr && int'(fl) == i)    nxt[i] = int'(cb);
         else if (cl && int'(fl) == i)    nxt[i] = 0;
         else if (inc_tgt)                nxt[i] = (mdl[i] + 1) % 65536;
         else                             nxt[i] = mdl[i];
      end
      if ((wr || cl) && fl == 3'd7) mz = (nxt[7] == 0);
      for (int i = 0; i < 8; i++) mdl[i] = nxt[i];
   endtask

   task automatic drive(input logic r, input logic wr, input logic [2:0] fl,
                        input logic [15:0] cb, input logic [2:0] inc, input logic ld,
                        input logic [15:0] md, input logic cl);
      exp_t e;
      @(negedge clk);
      rst      = r;
      c_wr     = wr;
      c_flag   = fl;
      C_bus    = cb;
      inc_flag = inc;
      mem_ld   = ld;
      mem_data = md;
      c_clr    = cl & CLR_BUILT;
      if (r) model_reset();
      else   model_step(wr, fl, cb, inc, ld, md, cl & CLR_BUILT);
      for (int i = 0; i < 8; i++) e.r[i] = 16'(mdl[i]);
      e.z = mz;
      exp_q.push_back(e);
   endtask

   task automatic check_reset_now();
      for (int i = 0; i < 8; i++) chk({"rst_", nm[i]}, dut_r[i], 16'h0000);
      chk("rst_z", {15'b0, z_flag}, 16'h0001);
   endtask

   // Monitor: after every rising edge, compare against the oldest expectation.
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            for (int i = 0; i < 8; i++) chk(nm[i], dut_r[i], e.r[i]);
            chk("z_flag", {15'b0, z_flag}, {15'b0, e.z});
         end
      end
   end

   initial begin
      rst = 1'b1; c_wr = 1'b0; c_flag = 3'd0; C_bus = 16'h0;
      inc_flag = 3'd0; mem_ld = 1'b0; mem_data = 16'h0; c_clr = 1'b0;
      model_reset();
      #1;
      check_reset_now();

      drive(0, 0, 0, 16'h0, 3'b000, 0, 16'h0, 0);

      for (int k = 0; k < 8; k++)
         drive(0, 1, 3'(k), 16'hA5A0 + 16'(k), 3'b000, 0, 16'h0, 0);

      drive(0, 1, 3'd0, 16'hFFFF, 3'b000, 0, 16'h0, 0);
      drive(0, 1, 3'd2, 16'h0007, 3'b000, 0, 16'h0, 0);
      drive(0, 0, 3'd0, 16'h0000, 3'b011, 0, 16'h0, 0);
      drive(0, 1, 3'd3, 16'hFFFF, 3'b000, 0, 16'h0, 0);
      drive(0, 0, 3'd0, 16'h0000, 3'b111, 0, 16'h0, 0);

      drive(0, 1, 3'd0, 16'h0100, 3'b001, 0, 16'h0, 0);
      drive(0, 1, 3'd1, 16'h1111, 3'b000, 1, 16'h00FF, 0);

      drive(0, 1, 3'd7, 16'h0000, 3'b000, 0, 16'h0, 0);
      drive(0, 1, 3'd7, 16'h0003, 3'b000, 0, 16'h0, 0);
      drive(0, 1, 3'd2, 16'h0000, 3'b000, 0, 16'h0, 0);

      if (CLR_BUILT) begin
         drive(0, 0, 3'd7, 16'h0000, 3'b000, 0, 16'h0, 1);
         drive(0, 1, 3'd3, 16'h0042, 3'b100, 0, 16'h0, 1);
         drive(0, 0, 3'd0, 16'h0000, 3'b001, 1, 16'h0055, 1);
      end

      for (int n = 0; n < 400; n++) begin
         drive(0, 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
               ($urandom_range(0, 7) == 0) ? 16'h0000 : 16'($urandom),
               3'($urandom_range(0, 7)), ($urandom_range(0, 3) == 0),
               16'($urandom), 1'($urandom_range(0, 1)));
      end

      drive(0, 1, 3'd4, 16'h1234, 3'b000, 0, 16'h0, 0);
      @(negedge clk);
      c_wr = 1'b0; inc_flag = 3'b000; mem_ld = 1'b0; c_clr = 1'b0;
      #2;
      rst = 1'b1;
      #1;
      check_reset_now();
      model_reset();
      drive(1, 1, 3'd5, 16'h5555, 3'b111, 1, 16'h7777, 0);
      drive(0, 1, 3'd5, 16'h0BEE, 3'b000, 0, 16'h0, 0);
      drive(0, 0, 3'd0, 16'h0000, 3'b111, 0, 16'h0, 0);

      @(negedge clk);
      c_wr = 1'b0; inc_flag = 3'b000; mem_ld = 1'b0; c_clr = 1'b0;
      for (int w = 0; w < 5 && exp_q.size() > 0; w++) @(negedge clk);
      if (exp_q.size() > 0) begin
         bad++;
         $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/cbus_reg_bank.md
CBUS_REG_BANK -- requirements
Module: cbus_reg_bank

Interface
REQ-001 The block SHALL have parameter WIDTH, default 16, which sets the data width of the C bus and of every register.
REQ-002 The block SHALL have the port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have the port rst, input, 1 bit: asynchronous active-high reset.
REQ-004 The block SHALL have the port c_wr, input, 1 bit: C-bus write strobe.
REQ-005 The block SHALL have the port c_flag, input, 3 bits: write destination code; 0 PC, 1 DR, 2 R1, 3 R2, 4 R3, 5 R4, 6 R5, 7 AC.
REQ-006 The block SHALL have the port C_bus, input, WIDTH bits: write-back data.
REQ-007 The block SHALL have the port inc_flag, input, 3 bits: increment requests; bit0 PC, bit1 R1, bit2 R2.
REQ-008 The block SHALL have the port mem_ld, input, 1 bit: load DR from mem_data.
REQ-009 The block SHALL have the port mem_data, input, WIDTH bits: memory read data.
REQ-010 The block SHALL have the ports PC, DR, R1, R2, R3, R4, R5 and AC, each an output of WIDTH bits: the registered contents, fed to the B-bus selector.
REQ-011 The block SHALL have the port z_flag, output, 1 bit: set when the last value written to AC was zero.

Function
REQ-012 A write with c_wr=1 SHALL load C_bus into the register selected by c_flag at the next rising edge, visible on its output one cycle after the strobe.
REQ-013 A write with c_wr=0 SHALL leave all registers unchanged, unless an increment or mem_ld applies.
REQ-014 For each set bit of inc_flag, the block SHALL add 1 modulo 2^WIDTH to the target register at the next edge, wrapping all-ones to 0.
REQ-015 Increments of PC, R1 and R2 SHALL proceed independently within the same cycle.
REQ-016 mem_ld=1 SHALL load mem_data into DR at the next edge.
REQ-017 Per-register priority SHALL be: mem_ld (DR only) > C-bus write > increment, and the losing request SHALL be dropped, not deferred.
REQ-018 On every edge on which AC is loaded, z_flag SHALL register (loaded value == 0).
REQ-019 z_flag SHALL hold its value when AC is not loaded.
REQ-020 No output SHALL change combinationally from any input; all outputs are register outputs.
REQ-021 Non-targeted registers SHALL hold their value on every edge.

Reset
REQ-022 While rst=1, all registers SHALL be 0 and z_flag SHALL be 1, immediately and independent of clk.
REQ-023 A write, increment or load coincident with rst SHALL be discarded.
REQ-024 The first update after rst falls SHALL occur at the first rising edge with rst=0.

Configuration
REQ-025 With macro CBUS_CLR_EN defined, the block SHALL add input port c_clr (1 bit).
REQ-026 With CBUS_CLR_EN defined, c_clr=1 with c_wr=0 SHALL zero the register selected by c_flag at the next edge, with priority above increment and below mem_ld.
REQ-027 With CBUS_CLR_EN defined, c_clr=1 with c_wr=1 SHALL let the write win.
REQ-028 With CBUS_CLR_EN defined, clearing AC SHALL set z_flag to 1.
REQ-029 Without CBUS_CLR_EN, port c_clr SHALL be absent and the behaviour SHALL be exactly REQ-012..REQ-021.

Structure
REQ-030 Shared package cbus_pkg SHALL hold the WIDTH default and the destination code constants (DST_PC..DST_AC), common with the B-bus selector codes 0-6.
REQ-031 One sub-module, inc_reg, SHALL implement a WIDTH-bit register with load, increment and (optionally) clear inputs and fixed priority, instantiated for PC, R1 and R2.
REQ-032 The remaining registers SHALL be plain load registers.

Verification
REQ-033 The bench SHALL check reset: assert rst mid-run with R3=0x1234 -> all outputs 0x0000 and z_flag=1 without a clock edge.
REQ-034 The bench SHALL check write/decode: c_wr=1, each c_flag 0..7 with C_bus=0xA5A0+code -> only that register updates, one cycle later; all others hold.
REQ-035 The bench SHALL check wrap: PC=0xFFFF, inc_flag=3'b001 -> PC=0x0000; concurrently R1=0x0007 with bit1 set -> R1=0x0008.
REQ-036 The bench SHALL check conflict: c_wr=1, c_flag=0, C_bus=0x0100 with inc_flag bit0 -> PC=0x0100 (not 0x0101); mem_ld=1 with mem_data=0x00FF plus a write to DR of 0x1111 -> DR=0x00FF.
REQ-037 The bench SHALL check z_flag: write AC=0x0000 -> z_flag=1; write AC=0x0003 -> z_flag=0; write R1 only -> z_flag holds 0.
REQ-038 The bench SHALL check the CBUS_CLR_EN build: c_clr=1, c_flag=7 with AC=0x0003 -> AC=0, z_flag=1; c_clr=1 with c_wr=1, C_bus=0x0042 on R2 -> R2=0x0042.
